gpio_input_conditioner: RTL and testbench
=========================================

GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning number of GPIO input lines.
REQ-002 SHALL have parameter DBNC_W, default 8, meaning width of the debounce threshold and of each per-line counter.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port din_async, input, WIDTH, meaning raw pad inputs, asynchronous to clk.
REQ-006 SHALL have port dbnc_cycles, input, DBNC_W, meaning the debounce threshold; 0 disables filtering.
REQ-007 SHALL have port rier, input, WIDTH, meaning per-line rising-edge interrupt enable.
REQ-008 SHALL have port fier, input, WIDTH, meaning per-line falling-edge interrupt enable.
REQ-009 SHALL have port ier, input, WIDTH, meaning per-line interrupt-to-irq enable.
REQ-010 SHALL have port isr_clr, input, WIDTH, meaning single-cycle write-1-to-clear strobe for isr bits.
REQ-011 SHALL have port idr, output, WIDTH, meaning the registered, debounced input value.
REQ-012 SHALL have port isr, output, WIDTH, meaning the registered, sticky interrupt status.
REQ-013 SHALL have port edge_rise, output, WIDTH, meaning a one-cycle pulse when an idr bit goes 0->1.
REQ-014 SHALL have port edge_fall, output, WIDTH, meaning a one-cycle pulse when an idr bit goes 1->0.
REQ-015 SHALL have port irq, output, 1, meaning the combined interrupt request.

Function
REQ-016 SHALL pass each din_async bit through a 2-flop synchronizer; sync[i] is the second-stage output.
REQ-017 SHALL keep one DBNC_W-bit counter per line: if sync[i]==idr[i], the counter clears to 0.
REQ-018 SHALL, when sync[i]!=idr[i] and counter[i]==dbnc_cycles, toggle idr[i] and clear counter[i] on the same edge.
REQ-019 SHALL otherwise increment counter[i]; the counter never wraps, because it clears at the threshold.
REQ-020 SHALL give a latency of dbnc_cycles+3 clk edges from a stable pad change to the idr update (2 synchronizer edges + dbnc_cycles+1 debounce edges).
REQ-021 SHALL reject any glitch shorter than dbnc_cycles+1 synchronized cycles, with no idr change.
REQ-022 SHALL apply a change of dbnc_cycles on the next edge; a counter already above a newly lowered threshold updates idr on its next mismatching cycle.
REQ-023 SHALL register edge_rise[i] and edge_fall[i] high for exactly the one cycle after idr[i] toggles.
REQ-024 SHALL set isr[i] on the edge following a qualifying event: (edge_rise[i]&rier[i])|(edge_fall[i]&fier[i]).
REQ-025 SHALL clear isr[i] when isr_clr[i]=1; if a set event and a clear coincide on the same line, set wins.
REQ-026 SHALL drive irq combinationally as the OR-reduction of isr&ier.
REQ-027 SHALL keep isr bits set when ier is deasserted, so that only irq masking changes.

Reset
REQ-028 SHALL asynchronously clear synchronizer flops, counters, idr, isr, edge_rise and edge_fall to 0 on rst_n=0; irq therefore reads 0.
REQ-029 SHALL report a pad held at 1 through reset release as a rising edge about dbnc_cycles+3 cycles after release; it sets isr only if rier is already enabled.
REQ-030 SHALL, on reset mid-debounce, discard any pending transition.

Structure
REQ-031 SHALL place the GPIO_WIDTH constant (32) and the DBNC_W default in gpio_pkg, shared with the register block.
REQ-032 SHALL implement per-line synchronizer, counter and idr bit as sub-module gpio_debounce_bit, instantiated WIDTH times via generate.
REQ-033 SHALL keep the edge, isr and irq logic in the top module.

Verification
REQ-034 SHALL cover: dbnc_cycles=0, din_async[0] 0->1 -> idr[0]=1 after 3 edges, edge_rise[0] pulses exactly 1 cycle.
REQ-035 SHALL cover: dbnc_cycles=4, 3-cycle high glitch on din_async[5] -> idr[5] stays 0 and no edge pulses; a 10-cycle high pulse -> idr[5]=1 after 7 edges.
REQ-036 SHALL cover: rier[3]=1, ier[3]=1, line 3 rises -> isr=0x0000_0008, irq=1; isr_clr=0x8 -> isr=0, irq=0.
REQ-037 SHALL cover: fier[7]=1, line 7 falls on the same cycle isr_clr[7]=1 -> isr[7] remains 1.
REQ-038 SHALL cover: isr[2]=1 with ier[2]=0 -> irq=0; then set ier[2]=1 -> irq=1 with no other input change.
REQ-039 SHALL cover: rst_n pulled low while a counter=3 of threshold 8 is pending -> all outputs are 0 immediately, and no stale edge appears after release with the pad at 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO constants used by the input conditioner and the register block.
package gpio_pkg;

    localparam int GPIO_WIDTH  = 32;
    localparam int GPIO_DBNC_W = 8;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO line: 2-flop synchronizer followed by a counter-based debounce filter.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DBNC_W = GPIO_DBNC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_din_async,
    input  logic [DBNC_W-1:0] i_dbnc_cycles,
    output logic              o_idr,
    output logic              o_toggle
);

    logic              r_sync1;
    logic              r_sync2;
    logic [DBNC_W-1:0] r_cnt;
    logic              r_idr;
    logic [DBNC_W-1:0] w_cnt_nxt;
    logic              w_toggle;

    // Debounce decision; >= lets a freshly lowered threshold take effect at once
    always_comb begin
        w_toggle  = 1'b0;
        w_cnt_nxt = r_cnt;
        if (r_sync2 == r_idr) begin
            w_cnt_nxt = '0;
        end else if (r_cnt >= i_dbnc_cycles) begin
            w_toggle  = 1'b1;
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + DBNC_W'(1);
        end
    end

    // Synchronizer, counter and debounced value registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_idr   <= 1'b0;
        end else begin
            r_sync1 <= i_din_async;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_nxt;
            if (w_toggle) begin
                r_idr <= ~r_idr;
            end else begin
                r_idr <= r_idr;
            end
        end
    end

    assign o_idr    = r_idr;
    assign o_toggle = w_toggle;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-line debounce, edge pulses, sticky status and irq.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int WIDTH  = GPIO_WIDTH,
    parameter int DBNC_W = GPIO_DBNC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din_async,
    input  logic [DBNC_W-1:0] dbnc_cycles,
    input  logic [WIDTH-1:0]  rier,
    input  logic [WIDTH-1:0]  fier,
    input  logic [WIDTH-1:0]  ier,
    input  logic [WIDTH-1:0]  isr_clr,
    output logic [WIDTH-1:0]  idr,
    output logic [WIDTH-1:0]  isr,
    output logic [WIDTH-1:0]  edge_rise,
    output logic [WIDTH-1:0]  edge_fall,
    output logic              irq
);

    logic [WIDTH-1:0] w_idr;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_isr_set;
    logic [WIDTH-1:0] r_edge_rise;
    logic [WIDTH-1:0] r_edge_fall;
    logic [WIDTH-1:0] r_isr;

    for (genvar g = 0; g < WIDTH; g++) begin : g_line
        gpio_debounce_bit #(
            .DBNC_W(DBNC_W)
        ) u_dbnc (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_din_async  (din_async[g]),
            .i_dbnc_cycles(dbnc_cycles),
            .o_idr        (w_idr[g]),
            .o_toggle     (w_toggle[g])
        );
    end

    assign w_isr_set = (r_edge_rise & rier) | (r_edge_fall & fier);

    // Edge pulses coincide with the new idr value; set beats clear in isr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_rise <= '0;
            r_edge_fall <= '0;
            r_isr       <= '0;
        end else begin
            r_edge_rise <= w_toggle & ~w_idr;
            r_edge_fall <= w_toggle & w_idr;
            r_isr       <= (r_isr & ~isr_clr) | w_isr_set;
        end
    end

    assign idr       = w_idr;
    assign isr       = r_isr;
    assign edge_rise = r_edge_rise;
    assign edge_fall = r_edge_fall;
    assign irq       = |(r_isr & ier);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner.
module tb_gpio_input_conditioner;

    logic        clk;
    logic        rst_n;
    logic [31:0] din_async;
    logic [7:0]  dbnc_cycles;
    logic [31:0] rier;
    logic [31:0] fier;
    logic [31:0] ier;
    logic [31:0] isr_clr;
    logic [31:0] idr;
    logic [31:0] isr;
    logic [31:0] edge_rise;
    logic [31:0] edge_fall;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] acc_edges;
    logic [31:0] acc_idr;

    gpio_input_conditioner #(
        .WIDTH (32),
        .DBNC_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_async  (din_async),
        .dbnc_cycles(dbnc_cycles),
        .rier       (rier),
        .fier       (fier),
        .ier        (ier),
        .isr_clr    (isr_clr),
        .idr        (idr),
        .isr        (isr),
        .edge_rise  (edge_rise),
        .edge_fall  (edge_fall),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for sampling/driving
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        din_async   = 32'h0;
        dbnc_cycles = 8'd0;
        rier        = 32'h0;
        fier        = 32'h0;
        ier         = 32'h0;
        isr_clr     = 32'h0;
        step(2);
        check("rst_idr", idr, 32'h0);
        check("rst_isr", isr, 32'h0);
        check("rst_rise", edge_rise, 32'h0);
        check("rst_fall", edge_fall, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        step(2);

        // Zero threshold: three-edge latency, one-cycle rise pulse
        din_async = 32'h0000_0001;
        step(2);
        check("d0_idr_e2", idr, 32'h0);
        step(1);
        check("d0_idr_e3", idr, 32'h0000_0001);
        check("d0_rise_e3", edge_rise, 32'h0000_0001);
        step(1);
        check("d0_rise_e4", edge_rise, 32'h0);
        check("d0_idr_e4", idr, 32'h0000_0001);

        // Threshold 4: 3-cycle glitch rejected, 10-cycle pulse accepted
        dbnc_cycles = 8'd4;
        acc_edges   = 32'h0;
        acc_idr     = 32'h0;
        din_async   = 32'h0000_0021;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) din_async = 32'h0000_0001;
            step(1);
            acc_edges = acc_edges | edge_rise | edge_fall;
            acc_idr   = acc_idr | (idr & 32'h0000_0020);
        end
        check("glitch_edges", acc_edges, 32'h0);
        check("glitch_idr5", acc_idr, 32'h0);
        din_async = 32'h0000_0021;
        step(6);
        check("pulse_idr_e6", idr, 32'h0000_0001);
        step(1);
        check("pulse_idr_e7", idr, 32'h0000_0021);
        check("pulse_rise_e7", edge_rise, 32'h0000_0020);
        step(3);
        din_async = 32'h0000_0001;
        step(7);
        check("pulse_fall_idr", idr, 32'h0000_0001);
        check("pulse_fall_edge", edge_fall, 32'h0000_0020);
        check("no_isr_unenabled", isr, 32'h0);

        // Rising interrupt on line 3, then write-1-to-clear
        dbnc_cycles = 8'd0;
        rier        = 32'h0000_0008;
        ier         = 32'h0000_0008;
        din_async   = 32'h0000_0009;
        step(3);
        check("l3_rise", edge_rise, 32'h0000_0008);
        check("l3_isr_pre", isr, 32'h0);
        step(1);
        check("l3_isr", isr, 32'h0000_0008);
        check("l3_irq", {31'h0, irq}, 32'h1);
        isr_clr = 32'h0000_0008;
        step(1);
        isr_clr = 32'h0;
        check("l3_isr_clr", isr, 32'h0);
        check("l3_irq_clr", {31'h0, irq}, 32'h0);

        // Falling event on line 7 coinciding with clear: set wins
        fier      = 32'h0000_0080;
        din_async = 32'h0000_0089;
        step(4);
        din_async = 32'h0000_0009;
        step(3);
        check("l7_fall", edge_fall, 32'h0000_0080);
        isr_clr = 32'h0000_0080;
        step(1);
        isr_clr = 32'h0;
        check("l7_set_wins", isr, 32'h0000_0080);
        isr_clr = 32'h0000_0080;
        step(1);
        isr_clr = 32'h0;
        check("l7_cleared", isr, 32'h0);

        // isr stays sticky under ier mask; enabling ier raises irq combinationally
        rier      = 32'h0000_0004;
        fier      = 32'h0;
        din_async = 32'h0000_000D;
        step(4);
        check("l2_isr_masked", isr, 32'h0000_0004);
        check("l2_irq_masked", {31'h0, irq}, 32'h0);
        ier = 32'h0000_000C;
        #1;
        check("l2_irq_enabled", {31'h0, irq}, 32'h1);

        // Reset in the middle of a threshold-8 debounce
        rier      = 32'h0;
        din_async = 32'h0;
        step(5);
        check("pre_rst_idr", idr, 32'h0);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        dbnc_cycles = 8'd8;
        din_async   = 32'h0000_0200;
        step(5);
        check("pending_idr", idr, 32'h0);
        rst_n     = 1'b0;
        din_async = 32'h0;
        #1;
        check("mid_rst_idr", idr, 32'h0);
        check("mid_rst_isr", isr, 32'h0);
        check("mid_rst_edges", edge_rise | edge_fall, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        step(2);
        rst_n     = 1'b1;
        acc_edges = 32'h0;
        acc_idr   = 32'h0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            acc_edges = acc_edges | edge_rise | edge_fall;
            acc_idr   = acc_idr | idr;
        end
        check("post_rst_edges", acc_edges, 32'h0);
        check("post_rst_idr", acc_idr, 32'h0);

        // Lowering the threshold below a running count updates on the next edge
        din_async = 32'h0000_0002;
        step(7);
        check("lower_idr_pre", idr, 32'h0);
        dbnc_cycles = 8'd2;
        step(1);
        check("lower_idr_post", idr, 32'h0000_0002);

        // Pad held high through reset release reports a rise after dbnc+3 edges
        rier      = 32'h0000_0010;
        rst_n     = 1'b0;
        din_async = 32'h0000_0012;
        step(2);
        rst_n = 1'b1;
        step(4);
        check("hold_idr_e4", idr, 32'h0);
        step(1);
        check("hold_idr_e5", idr, 32'h0000_0012);
        check("hold_rise_e5", edge_rise, 32'h0000_0012);
        check("hold_isr_e5", isr, 32'h0);
        step(1);
        check("hold_isr_e6", isr, 32'h0000_0010);
        check("hold_irq_e6", {31'h0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
